// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 arbitrated mux: mode encodings, grant
// record and the round-robin next-grant search.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int unsigned MAX_N  = 16;
  localparam int unsigned MAX_SW = 4;

  typedef struct packed {
    logic              found;
    logic [MAX_SW-1:0] idx;
  } rr_grant_t;

  // First valid channel scanning ptr+1, ptr+2, ... mod n; ptr itself is checked last.
  function automatic rr_grant_t rr_next(input logic [MAX_N-1:0]  valid,
                                        input logic [MAX_SW-1:0] ptr,
                                        input int unsigned       n);
    rr_grant_t   r;
    int unsigned idx;
    r = '0;
    for (int unsigned k = 1; k <= MAX_N; k++) begin
      idx = (32'(ptr) + k) % n;
      if (k <= n && !r.found && valid[MAX_SW'(idx)]) begin
        r.found = 1'b1;
        r.idx   = MAX_SW'(idx);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the next valid channel after ptr.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [SW-1:0] ptr,
  input  logic          enable,
  output logic [SW-1:0] grant_idx_c,
  output logic          grant_valid_c
);

  rr_grant_t r;

  always_comb begin
    r             = rr_next(MAX_N'(valid), MAX_SW'(ptr), N);
    grant_idx_c   = SW'(r.idx);
    grant_valid_c = enable && r.found;
  end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-input registered stream mux with fixed-select or round-robin arbitration
// and valid/ready handshakes on every channel and on the output.
module mux_arb_nto1
  import mux_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 8,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  output logic [SW-1:0]  out_src,
  input  logic           out_ready
);

  localparam logic [SW:0] N_LIM = (SW+1)'(N);

  logic [W-1:0]  chan [N];
  logic [SW-1:0] ptr;
  logic [SW-1:0] rr_idx_c;
  logic          rr_valid_c;
  logic          sel_ok_c;
  logic          fixed_gnt_c;
  logic          load_c;
  logic          grant_valid_c;
  logic [SW-1:0] grant_idx_c;

  for (genvar i = 0; i < N; i++) begin : g_chan
    assign chan[i] = in_data[i*W +: W];
  end

  rr_arbiter #(.N(N), .SW(SW)) u_rr (
    .valid         (in_valid),
    .ptr           (ptr),
    .enable        (mode == MODE_RR),
    .grant_idx_c   (rr_idx_c),
    .grant_valid_c (rr_valid_c)
  );

  // Grant selection and per-channel ready; at most one ready bit is high.
  always_comb begin
    sel_ok_c      = {1'b0, sel} < N_LIM;
    fixed_gnt_c   = sel_ok_c && in_valid[sel];
    load_c        = !out_valid || out_ready;
    grant_valid_c = (mode == MODE_RR) ? rr_valid_c : fixed_gnt_c;
    grant_idx_c   = (mode == MODE_RR) ? rr_idx_c : sel;
    in_ready      = '0;
    if (load_c && grant_valid_c && !rst) begin
      in_ready[grant_idx_c] = 1'b1;
    end
  end

  // Output stage and round-robin pointer; ptr follows the last grant in both modes.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= SW'(N - 1);
    end else if (load_c) begin
      if (grant_valid_c) begin
        out_valid <= 1'b1;
        out_data  <= chan[grant_idx_c];
        out_src   <= grant_idx_c;
        ptr       <= grant_idx_c;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Self-checking bench for mux_arb_nto1: directed steps followed by random
// traffic, all compared against a cycle-level reference model.
module tb_mux_arb_nto1;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [SW-1:0]  out_src;
  logic           out_ready;

  int tests = 0;
  int fails = 0;

  // Reference state
  bit         m_valid;
  logic [7:0] m_data;
  int         m_src;
  int         m_ptr;

  always #5 clk = ~clk;

  mux_arb_nto1 #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel the spec's rules would grant right now, or -1.
  function automatic int model_grant();
    if (mode == 1'b1) begin
      for (int k = 1; k <= N; k++) begin
        if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
    end
    if (int'(sel) < N && in_valid[sel]) return int'(sel);
    return -1;
  endfunction

  // One clock: check ready before the edge, advance the model, check outputs after.
  task automatic step();
    int         g;
    bit         load;
    logic [3:0] exp_rdy;
    #1;
    load    = !m_valid || out_ready;
    g       = model_grant();
    exp_rdy = '0;
    if (!rst && load && g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = 8'h00; m_src = 0; m_ptr = N - 1;
    end else if (load) begin
      if (g >= 0) begin
        m_valid = 1; m_data = in_data[g*W +: W]; m_src = g; m_ptr = g;
      end else begin
        m_valid = 0;
      end
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_src", 32'(out_src), 32'(m_src));
    @(negedge clk);
  endtask

  initial begin
    int rr_seq [8];
    rr_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
    m_valid = 0; m_data = 8'h00; m_src = 0; m_ptr = N - 1;

    // Reset with every channel requesting
    rst = 1'b1; mode = 1'b1; sel = '0; out_ready = 1'b1;
    in_valid = 4'b1111; in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    @(negedge clk);
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    #1 chk("rst_in_ready", 32'(in_ready), 32'd0);

    // Round-robin full load rotates 0..3
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_full_src", 32'(out_src), 32'(rr_seq[i]));
      chk("rr_full_data", 32'(out_data), 32'(8'h11 + 8'(8'h11 * rr_seq[i])));
    end

    // Fixed select of channel 2, sustained
    mode = 1'b0; sel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      #1 chk("fixed_in_ready", 32'(in_ready), 32'h4);
      step();
      chk("fixed_data", 32'(out_data), 32'h33);
      chk("fixed_src", 32'(out_src), 32'd2);
    end

    // Sparse round-robin from reset: 1,3,1,3 then only channel 1
    rst = 1'b1; step(); rst = 1'b0;
    mode = 1'b1; in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sparse_src", 32'(out_src), (i % 2 == 0) ? 32'd1 : 32'd3);
    end
    in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sparse1_src", 32'(out_src), 32'd1);
    end

    // Backpressure holds channel 1 beat (8'h22), then the next beat loads at once
    in_valid = 4'b1010; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
      step();
      chk("bp_hold_data", 32'(out_data), 32'h22);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_src", 32'(out_src), 32'd3);
    chk("bp_release_data", 32'(out_data), 32'h44);

    // Mode switch: ptr=3 -> 0, 1; fixed sel=3 -> 3; back to RR -> 0
    in_valid = 4'b1111;
    step(); chk("ms_src0", 32'(out_src), 32'd0);
    step(); chk("ms_src1", 32'(out_src), 32'd1);
    mode = 1'b0; sel = 2'd3;
    step(); chk("ms_fixed3", 32'(out_src), 32'd3);
    mode = 1'b1;
    step(); chk("ms_rr0", 32'(out_src), 32'd0);

    // Reset while a beat is held
    out_ready = 1'b0; rst = 1'b1;
    step(); chk("midrst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    step(); chk("post_rst_src", 32'(out_src), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      in_data   = 32'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
